ram_stream_writer: RTL and testbench

- Write-side master for the single-read-port RAM. It accepts a burst of data words over a valid/ready handshake and drives the RAM write port: write enable, write address and write data.
- Words land at consecutive addresses, starting at a programmable base address, for a programmable word count.
- It fills data memory from a producer (loader, UART receiver, test source) while the datapath reads through the RAM's read port.

---
 rtl/ram_stream_writer_pkg.sv | 14 +
 rtl/ram_stream_writer_if.sv | 24 ++
 rtl/ram_writer_addr_gen.sv | 42 ++++
 rtl/ram_stream_writer.sv | 113 +++++++++++
 tb/tb_ram_stream_writer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_writer_pkg.sv
// rtl/ram_stream_writer_pkg.sv - shared widths and FSM state encoding for the RAM stream writer
package ram_stream_writer_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_LEN_WIDTH  = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/ram_stream_writer_if.sv
// rtl/ram_stream_writer_if.sv - valid/ready word stream feeding the RAM stream writer
interface ram_stream_writer_if
   import ram_stream_writer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
)();

   logic                  iValid;
   logic [DATA_WIDTH-1:0] iData;
   logic                  oReady;

   modport master (
      output iValid,
      output iData,
      input  oReady
   );

   modport slave (
      input  iValid,
      input  iData,
      output oReady
   );

endinterface

// File: rtl/ram_writer_addr_gen.sv
// rtl/ram_writer_addr_gen.sv - latched base/length, word counter and wrapped write address
module ram_writer_addr_gen
   import ram_stream_writer_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
)(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iLoad,
   input  logic                  iIncrement,
   input  logic [ADDR_WIDTH-1:0] iBase,
   input  logic [LEN_WIDTH-1:0]  iLength,
   output logic [ADDR_WIDTH-1:0] oAddress,
   output logic [LEN_WIDTH-1:0]  oCount,
   output logic                  oLast
);

   logic [ADDR_WIDTH-1:0] r_base;
   logic [LEN_WIDTH-1:0]  r_length;
   logic [LEN_WIDTH-1:0]  r_count;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_base   <= '0;
         r_length <= '0;
         r_count  <= '0;
      end else if (iLoad) begin
         r_base   <= iBase;
         r_length <= iLength;
         r_count  <= '0;
      end else if (iIncrement) begin
         r_count  <= r_count + LEN_WIDTH'(1);
      end
   end

   // Truncating the sum to ADDR_WIDTH gives the modulo wrap past the top of RAM.
   assign oAddress = r_base + ADDR_WIDTH'(r_count);
   assign oCount   = r_count;
   assign oLast    = (r_count == r_length - LEN_WIDTH'(1));

endmodule

// File: rtl/ram_stream_writer.sv
// rtl/ram_stream_writer.sv - burst writer: accepts a word stream and drives the RAM write port
module ram_stream_writer
   import ram_stream_writer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
)(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iStart,
   input  logic [ADDR_WIDTH-1:0] iBaseAddress,
   input  logic [LEN_WIDTH-1:0]  iLength,
   ram_stream_writer_if.slave    bus,
   output logic                  oWriteEnable,
   output logic [ADDR_WIDTH-1:0] oWriteAddress,
   output logic [DATA_WIDTH-1:0] oWriteData,
   output logic                  oBusy,
   output logic                  oDone,
   output logic [LEN_WIDTH-1:0]  oWordCount
);

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_ready;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_handshake;
   logic                  w_load;
   logic                  w_last;
   logic [ADDR_WIDTH-1:0] w_address;
   logic                  r_write_enable;
   logic [ADDR_WIDTH-1:0] r_write_address;
   logic [DATA_WIDTH-1:0] r_write_data;

   assign w_handshake = (r_state == ST_WRITE) && bus.iValid;
   assign w_load      = (r_state == ST_IDLE) && iStart;

   ram_writer_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_addr_gen (
      .Clock      (Clock),
      .Reset      (Reset),
      .iLoad      (w_load),
      .iIncrement (w_handshake),
      .iBase      (iBaseAddress),
      .iLength    (iLength),
      .oAddress   (w_address),
      .oCount     (oWordCount),
      .oLast      (w_last)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_ready      = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (iStart) begin
               w_next_state = (iLength == '0) ? ST_DONE : ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_ready = 1'b1;
            w_busy  = 1'b1;
            if (w_handshake && w_last) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_busy       = 1'b1;
            w_done       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // The final word is written one cycle after its handshake, i.e. alongside oDone.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_write_enable  <= 1'b0;
         r_write_address <= '0;
         r_write_data    <= '0;
      end else begin
         r_write_enable <= w_handshake;
         if (w_handshake) begin
            r_write_address <= w_address;
            r_write_data    <= bus.iData;
         end
      end
   end

   assign bus.oReady    = w_ready;
   assign oBusy         = w_busy;
   assign oDone         = w_done;
   assign oWriteEnable  = r_write_enable;
   assign oWriteAddress = r_write_address;
   assign oWriteData    = r_write_data;

endmodule

// File: tb/tb_ram_stream_writer.sv
// tb/tb_ram_stream_writer.sv - scoreboard bench for ram_stream_writer
module tb_ram_stream_writer;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int LW = 9;

   typedef logic [AW+DW:0] rec_t;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          iStart;
   logic [AW-1:0] iBaseAddress;
   logic [LW-1:0] iLength;
   logic          oWriteEnable;
   logic [AW-1:0] oWriteAddress;
   logic [DW-1:0] oWriteData;
   logic          oBusy;
   logic          oDone;
   logic [LW-1:0] oWordCount;

   rec_t exp_q[$];
   rec_t obs_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_cycles = 0;
   int   done_cycles = 0;

   ram_stream_writer_if #(.DATA_WIDTH(DW)) bus();

   ram_stream_writer #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW)
   ) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .iStart        (iStart),
      .iBaseAddress  (iBaseAddress),
      .iLength       (iLength),
      .bus           (bus),
      .oWriteEnable  (oWriteEnable),
      .oWriteAddress (oWriteAddress),
      .oWriteData    (oWriteData),
      .oBusy         (oBusy),
      .oDone         (oDone),
      .oWordCount    (oWordCount)
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock) begin
      if (oWriteEnable === 1'b1) obs_q.push_back({oWriteAddress, oWriteData, oDone});
      if (bus.oReady === 1'b1) ready_cycles++;
      if (oDone === 1'b1) done_cycles++;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic send_burst(input logic [AW-1:0] base, input logic [LW-1:0] len,
                             input logic [DW-1:0] dbase, input int gap_after,
                             input int gap_len, input int poke_at);
      logic [AW-1:0] a;
      int w;
      iBaseAddress = base;
      iLength      = len;
      iStart       = 1'b1;
      tick();
      iStart       = 1'b0;
      iBaseAddress = 8'h55;
      iLength      = 9'd77;
      for (int k = 0; k < int'(len); k++) begin
         if (k == gap_after) begin
            bus.iValid = 1'b0;
            repeat (gap_len) tick();
         end
         bus.iValid = 1'b1;
         bus.iData  = DW'(int'(dbase) + k);
         if (k == poke_at) begin
            iStart       = 1'b1;
            iBaseAddress = 8'h40;
            iLength      = 9'd2;
         end
         w = 0;
         while (bus.oReady !== 1'b1 && w < 16) begin
            tick();
            w++;
         end
         if (bus.oReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout word %0d got oReady %b exp 1", k, bus.oReady);
         end
         a = base + AW'(k);
         exp_q.push_back({a, DW'(int'(dbase) + k), (k == int'(len) - 1)});
         tick();
         iStart = 1'b0;
      end
      bus.iValid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) begin
         iStart       = 1'($urandom);
         bus.iValid   = 1'($urandom);
         bus.iData    = DW'($urandom);
         iBaseAddress = AW'($urandom);
         iLength      = LW'($urandom);
         tick();
      end
      checks++;
      if ({oWriteEnable, oBusy, oDone, bus.oReady} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0000", {oWriteEnable, oBusy, oDone, bus.oReady});
      end
      checks++;
      if ({oWriteAddress, oWriteData, oWordCount} !== '0) begin
         errors++;
         $display("FAIL reset_values got addr %h data %h count %0d exp 0", oWriteAddress, oWriteData, oWordCount);
      end
      Reset      = 1'b0;
      iStart     = 1'b0;
      bus.iValid = 1'b0;
      bus.iData  = '0;
      tick();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_basic();
      rec_t e, o;
      ready_cycles = 0;
      done_cycles  = 0;
      send_burst(8'h10, 9'd4, 16'hA000, -1, 0, -1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL basic_write missing got none exp %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL basic_write got %h exp %h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra got %0d exp 0", obs_q.size()); end
      checks++;
      if (ready_cycles != 4) begin errors++; $display("FAIL basic_ready_cycles got %0d exp 4", ready_cycles); end
      checks++;
      if (done_cycles != 1) begin errors++; $display("FAIL basic_done_cycles got %0d exp 1", done_cycles); end
      checks++;
      if (oWordCount !== 9'd4) begin errors++; $display("FAIL basic_count got %0d exp 4", oWordCount); end
      obs_q.delete();
   endtask

   task automatic test_gap();
      rec_t e, o;
      send_burst(8'h10, 9'd4, 16'hA000, 2, 2, -1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL gap_write missing got none exp %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL gap_write got %h exp %h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL gap_extra got %0d exp 0", obs_q.size()); end
      checks++;
      if (oWordCount !== 9'd4) begin errors++; $display("FAIL gap_count got %0d exp 4", oWordCount); end
      obs_q.delete();
   endtask

   task automatic test_wrap();
      rec_t e, o;
      send_burst(8'hFE, 9'd4, 16'hB000, -1, 0, -1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL wrap_write missing got none exp %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL wrap_write got %h exp %h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_extra got %0d exp 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_zero_length();
      iBaseAddress = 8'h33;
      iLength      = 9'd0;
      iStart       = 1'b1;
      tick();
      iStart = 1'b0;
      checks++;
      if ({oDone, oBusy, bus.oReady} !== 3'b110) begin
         errors++;
         $display("FAIL zero_done_state got done/busy/ready %b exp 110", {oDone, oBusy, bus.oReady});
      end
      checks++;
      if (oWordCount !== 9'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", oWordCount); end
      tick();
      checks++;
      if ({oDone, oBusy} !== 2'b00) begin errors++; $display("FAIL zero_idle got done/busy %b exp 00", {oDone, oBusy}); end
      tick();
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL zero_writes got %0d exp 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_start_ignored();
      rec_t e, o;
      send_burst(8'h10, 9'd4, 16'hC000, -1, 0, 1);
      send_burst(8'h40, 9'd2, 16'hD000, -1, 0, -1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL ignore_write missing got none exp %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL ignore_write got %h exp %h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL ignore_extra got %0d exp 0", obs_q.size()); end
      checks++;
      if (oWordCount !== 9'd2) begin errors++; $display("FAIL ignore_count got %0d exp 2", oWordCount); end
      obs_q.delete();
   endtask

   task automatic test_reset_mid_burst();
      rec_t e, o;
      iBaseAddress = 8'h20;
      iLength      = 9'd6;
      iStart       = 1'b1;
      tick();
      iStart = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.iValid = 1'b1;
         bus.iData  = DW'(16'hE000 + k);
         exp_q.push_back({AW'(8'h20 + k), DW'(16'hE000 + k), 1'b0});
         tick();
      end
      bus.iData = 16'hE002;
      Reset     = 1'b1;
      tick();
      checks++;
      if ({oWriteEnable, oBusy, oDone, bus.oReady, oWriteAddress, oWriteData, oWordCount} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got we %b busy %b done %b rdy %b addr %h data %h cnt %0d exp all 0",
                  oWriteEnable, oBusy, oDone, bus.oReady, oWriteAddress, oWriteData, oWordCount);
      end
      Reset      = 1'b0;
      bus.iValid = 1'b0;
      tick();
      send_burst(8'h60, 9'd3, 16'hF000, -1, 0, -1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL midreset_write missing got none exp %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL midreset_write got %h exp %h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_extra got %0d exp 0", obs_q.size()); end
      checks++;
      if (oWordCount !== 9'd3) begin errors++; $display("FAIL midreset_count got %0d exp 3", oWordCount); end
      obs_q.delete();
   endtask

   initial begin
      Reset        = 1'b1;
      iStart       = 1'b0;
      iBaseAddress = '0;
      iLength      = '0;
      bus.iValid   = 1'b0;
      bus.iData    = '0;
      test_reset();
      test_basic();
      test_gap();
      test_wrap();
      test_zero_length();
      test_start_ignored();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
